// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared definitions for the ID-stage hazard control unit.
//   - default register-file geometry
//   - hazard_cause_e: encoding of the registered hazard-cause code
package hazard_scoreboard_unit_pkg;

    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef enum logic [2:0] {
        CauseNone      = 3'd0,
        CauseLoadUse   = 3'd1,
        CauseBranchDep = 3'd2,
        CauseMdRaw     = 3'd3,
        CauseMdStruct  = 3'd4,
        CauseMemWait   = 3'd5
    } hazard_cause_e;

endpackage

// File: rtl/hazard_scoreboard_unit_load_tracker.sv
// Load delay line: remembers the destinations of loads that left ID during the
// last LOAD_LAT advancing cycles and flags any ID source that matches one.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   advance                 shift the line (low while the pipeline is frozen)
//   push_valid, push_rd     entry written into slot 0 on advance
//   rs1_addr, rs2_addr      ID sources to compare
//   rs1_match, rs2_match    source matches a valid in-flight load
// Source qualification (uses_rsN, x0) is done by the caller.
module hazard_load_tracker #(
    parameter int unsigned AW       = 5,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    input  logic          push_valid,
    input  logic [AW-1:0] push_rd,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_match,
    output logic          rs2_match
);

    logic [LOAD_LAT-1:0]         valid_q;
    logic [LOAD_LAT-1:0][AW-1:0] rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rd_q    <= '0;
        end else if (advance) begin
            valid_q[0] <= push_valid;
            rd_q[0]    <= push_rd;
            for (int i = 1; i < int'(LOAD_LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                rd_q[i]    <= rd_q[i-1];
            end
        end
    end

    always_comb begin
        rs1_match = 1'b0;
        rs2_match = 1'b0;
        for (int i = 0; i < int'(LOAD_LAT); i++) begin
            rs1_match = rs1_match | (valid_q[i] & (rd_q[i] == rs1_addr));
            rs2_match = rs2_match | (valid_q[i] & (rd_q[i] == rs2_addr));
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard control beside the ID stage of the 5-stage pipeline.
// Detects load-use, branch-dependency, mul/div RAW/WAW and mul/div structural
// hazards, freezes everything on data-memory wait, flushes on taken branches,
// and records the winning stall cause plus saturating per-cause stall counters.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   id_*                               ID-stage instruction decode
//   ex_rd_addr, ex_reg_write           EX-stage destination
//   md_start/_rd, md_done/_rd, md_busy mul/div unit events and status
//   mem_ready, branch_taken            memory wait / branch resolution
//   stall_if, stall_id, stall_all      combinational stall controls
//   flush_id, flush_ex                 combinational squash controls
//   hazard_cause                       registered cause of the previous cycle
//   cnt_load/branch/md/mem             saturating stall-cycle counters
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int unsigned NREGS        = NREGS_DEFAULT,
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned BRANCH_IN_ID = 1,
    parameter int unsigned CNT_W        = 16,
    localparam int unsigned AW          = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1_addr,
    input  logic             id_uses_rs1,
    input  logic [AW-1:0]    id_rs2_addr,
    input  logic             id_uses_rs2,
    input  logic [AW-1:0]    id_rd_addr,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             id_is_muldiv,
    input  logic             id_branch,
    input  logic [AW-1:0]    ex_rd_addr,
    input  logic             ex_reg_write,
    input  logic             md_start,
    input  logic [AW-1:0]    md_start_rd,
    input  logic             md_done,
    input  logic [AW-1:0]    md_done_rd,
    input  logic             md_busy,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_all,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [2:0]       hazard_cause,
    output logic [CNT_W-1:0] cnt_load,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_md,
    output logic [CNT_W-1:0] cnt_mem
);

    localparam logic BranchInId = (BRANCH_IN_ID != 0);

    // Operand qualification; x0 never takes part in a hazard.
    logic rs1_used, rs2_used, rd_written;
    assign rs1_used   = id_uses_rs1 & (id_rs1_addr != '0);
    assign rs2_used   = id_uses_rs2 & (id_rs2_addr != '0);
    assign rd_written = id_reg_write & (id_rd_addr != '0);

    // ---------------- load delay line ----------------
    logic ld_rs1_match, ld_rs2_match, id_fire, ld_push;

    assign ld_push = id_fire & id_is_load & rd_written;

    hazard_load_tracker #(
        .AW       (AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_load_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (~stall_all),
        .push_valid (ld_push),
        .push_rd    (id_rd_addr),
        .rs1_addr   (id_rs1_addr),
        .rs2_addr   (id_rs2_addr),
        .rs1_match  (ld_rs1_match),
        .rs2_match  (ld_rs2_match)
    );

    // ---------------- mul/div scoreboard ----------------
    logic [NREGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (md_done)  busy_d[md_done_rd]  = 1'b0;
        if (md_start) busy_d[md_start_rd] = 1'b1;  // set wins over same-cycle clear
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // A register is pending if already busy or being claimed by a launch this cycle.
    logic rs1_pend, rs2_pend, rd_pend;
    assign rs1_pend = busy_q[id_rs1_addr] | (md_start & (md_start_rd == id_rs1_addr));
    assign rs2_pend = busy_q[id_rs2_addr] | (md_start & (md_start_rd == id_rs2_addr));
    assign rd_pend  = busy_q[id_rd_addr]  | (md_start & (md_start_rd == id_rd_addr));

    // ---------------- hazard detection ----------------
    logic hz_load, hz_branch, hz_md_raw, hz_md_struct, id_hazard;

    assign hz_load      = id_valid & ((rs1_used & ld_rs1_match) | (rs2_used & ld_rs2_match));
    assign hz_branch    = BranchInId & id_valid & id_branch & ex_reg_write & (ex_rd_addr != '0)
                        & ((rs1_used & (id_rs1_addr == ex_rd_addr))
                         | (rs2_used & (id_rs2_addr == ex_rd_addr)));
    assign hz_md_raw    = id_valid & ((rs1_used & rs1_pend) | (rs2_used & rs2_pend)
                                    | (rd_written & rd_pend));
    assign hz_md_struct = id_valid & id_is_muldiv & (md_busy | md_start);
    assign id_hazard    = hz_load | hz_branch | hz_md_raw | hz_md_struct;

    // Flush only when memory is ready; a flush releases the ID stall so the
    // squashed slot advances.
    assign stall_all = ~mem_ready;
    assign flush_id  = branch_taken & mem_ready;
    assign flush_ex  = flush_id & ~BranchInId;
    assign stall_id  = stall_all | (id_hazard & ~flush_id);
    assign stall_if  = stall_id;
    assign id_fire   = id_valid & ~stall_id & ~stall_all & ~flush_id;

    // ---------------- cause register and counters ----------------
    hazard_cause_e cause_d, cause_q;

    // Only cycles that actually stall get a cause.
    always_comb begin
        cause_d = CauseNone;
        if (stall_all)         cause_d = CauseMemWait;
        else if (!stall_id)    cause_d = CauseNone;
        else if (hz_load)      cause_d = CauseLoadUse;
        else if (hz_branch)    cause_d = CauseBranchDep;
        else if (hz_md_raw)    cause_d = CauseMdRaw;
        else if (hz_md_struct) cause_d = CauseMdStruct;
    end

    logic [3:0][CNT_W-1:0] cnt_q;
    logic [1:0]            cnt_sel;
    logic                  cnt_en;

    always_comb begin
        cnt_en  = 1'b1;
        cnt_sel = 2'd0;
        unique case (cause_d)
            CauseLoadUse:              cnt_sel = 2'd0;
            CauseBranchDep:            cnt_sel = 2'd1;
            CauseMdRaw, CauseMdStruct: cnt_sel = 2'd2;
            CauseMemWait:              cnt_sel = 2'd3;
            default:                   cnt_en  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= CauseNone;
            cnt_q   <= '0;
        end else begin
            cause_q <= cause_d;
            if (cnt_en && (cnt_q[cnt_sel] != '1)) begin
                cnt_q[cnt_sel] <= cnt_q[cnt_sel] + CNT_W'(1);
            end
        end
    end

    assign hazard_cause = cause_q;
    assign cnt_load     = cnt_q[0];
    assign cnt_branch   = cnt_q[1];
    assign cnt_md       = cnt_q[2];
    assign cnt_mem      = cnt_q[3];

endmodule
